// File: rtl/raven_pkg.sv
// Shared types and helpers for the systolic column drain logic.
package raven_pkg;

    // Operating mode of the column, sampled together with the start command.
    typedef enum logic [1:0] {
        GEMM = 2'b00,
        DIV  = 2'b01,
        EXP  = 2'b10,
        LOG  = 2'b11
    } gemm_uno_e;

    // Drain sequencer states.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_CAP  = 2'b10
    } drain_state_e;

    // Default activation width used across the array.
    localparam int ACT_BW = 16;

    // Largest value representable in a signed word of the given width.
    function automatic longint sat_hi(input int bw);
        return (longint'(1) <<< (bw - 1)) - longint'(1);
    endfunction

    // Smallest value representable in a signed word of the given width.
    function automatic longint sat_lo(input int bw);
        return -(longint'(1) <<< (bw - 1));
    endfunction

    localparam longint ACT_SAT_HI = sat_hi(ACT_BW);
    localparam longint ACT_SAT_LO = sat_lo(ACT_BW);

endpackage

// File: rtl/pe_sync_fifo.sv
// Small synchronous FIFO with a registered head word. Push is accepted when
// the FIFO has room or when a pop frees a slot in the same cycle.
module pe_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_BW = $clog2(DEPTH);
    localparam int CNT_BW = PTR_BW + 1;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [PTR_BW-1:0] wr_ptr;
    logic [PTR_BW-1:0] rd_ptr;
    logic [PTR_BW-1:0] rd_ptr_nxt;
    logic [CNT_BW-1:0] count;
    logic [CNT_BW-1:0] count_nxt;
    logic              pop_ok;
    logic              push_ok;

    assign full  = (count == CNT_BW'(DEPTH));
    assign empty = (count == '0);

    // Qualify push/pop and compute next read pointer and occupancy.
    always_comb begin
        pop_ok     = pop && !empty;
        push_ok    = push && (!full || pop_ok);
        rd_ptr_nxt = pop_ok ? rd_ptr + 1'b1 : rd_ptr;
        count_nxt  = count;
        if (push_ok && !pop_ok) begin
            count_nxt = count + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_nxt = count - 1'b1;
        end
    end

    // Storage, pointers and head register; the head bypasses storage when
    // the FIFO would otherwise be empty so a fresh word shows up next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            if (count_nxt != '0) begin
                if (count == {{(CNT_BW-1){1'b0}}, pop_ok}) begin
                    dout <= din;
                end else begin
                    dout <= mem[rd_ptr_nxt];
                end
            end
        end
    end

endmodule

// File: rtl/pe_col_drain.sv
// Drain stage below the bottom PE of a systolic column: runs a capture
// schedule, saturates/rounds the accumulator to the activation format and
// queues results on a valid/ready stream.
//
// state  | meaning
// S_IDLE | waiting for start_i
// S_RUN  | interval counter counting down to the next capture
// S_CAP  | one-cycle capture of acc_i into the FIFO
module pe_col_drain
    import raven_pkg::*;
#(
    parameter int INT_BW   = 5,
    parameter int FRA_BW   = 10,
    parameter int MUL_BW   = 16,
    parameter int ACC_BW   = 32,
    parameter int LEN_BW   = 10,
    parameter int REP_BW   = 8,
    parameter int ITER_LEN = 8,
    parameter int DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               gemm_uno,
    input  logic                     start_i,
    input  logic [LEN_BW-1:0]        len_i,
    input  logic [REP_BW-1:0]        nrep_i,
    input  logic signed [ACC_BW-1:0] acc_i,
    input  logic                     clr_i,
    output logic signed [MUL_BW-1:0] out_o,
    output logic                     out_vld_o,
    input  logic                     out_rdy_i,
    output logic                     busy_o,
    output logic                     sat_o,
    output logic                     drop_o
);

    localparam logic signed [ACC_BW-1:0] SAT_HI = ACC_BW'(sat_hi(MUL_BW));
    localparam logic signed [ACC_BW-1:0] SAT_LO = ACC_BW'(sat_lo(MUL_BW));
    localparam logic [LEN_BW-1:0]        ITER_M1 = LEN_BW'(ITER_LEN - 1);

    drain_state_e              state;
    gemm_uno_e                 mode_q;
    logic [LEN_BW-1:0]         len_m1_q;
    logic [LEN_BW-1:0]         int_cnt;
    logic [REP_BW-1:0]         rep_cnt;
    logic [LEN_BW-1:0]         gemm_len_m1;
    logic [REP_BW-1:0]         nrep_m1;
    logic signed [ACC_BW-1:0]  acc_shift;
    logic [MUL_BW-1:0]         cnv;
    logic                      sat_now;
    logic                      cap;
    logic                      pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      drop_now;
    logic [MUL_BW-1:0]         head;

    assign gemm_len_m1 = (len_i == '0) ? '0 : len_i - 1'b1;
    assign nrep_m1     = (nrep_i == '0) ? '0 : nrep_i - 1'b1;

    assign cap       = (state == S_CAP);
    assign busy_o    = (state != S_IDLE);
    assign out_vld_o = !fifo_empty;
    assign pop       = out_vld_o && out_rdy_i;
    assign drop_now  = cap && fifo_full && !pop;
    assign out_o     = head;

    // Saturate and truncate the Q.2F accumulator down to the Q.F activation.
    always_comb begin
        acc_shift = acc_i >>> FRA_BW;
        sat_now   = 1'b0;
        cnv       = acc_shift[MUL_BW-1:0];
        if (acc_shift > SAT_HI) begin
            cnv     = {1'b0, {(MUL_BW-1){1'b1}}};
            sat_now = 1'b1;
        end else if (acc_shift < SAT_LO) begin
            cnv     = {1'b1, {(MUL_BW-1){1'b0}}};
            sat_now = 1'b1;
        end
    end

    // Capture sequencer: interval countdown then a single capture cycle,
    // repeated until the repeat counter is exhausted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            mode_q   <= GEMM;
            len_m1_q <= '0;
            int_cnt  <= '0;
            rep_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        mode_q   <= gemm_uno_e'(gemm_uno);
                        len_m1_q <= gemm_len_m1;
                        int_cnt  <= (gemm_uno == GEMM) ? gemm_len_m1 : ITER_M1;
                        rep_cnt  <= nrep_m1;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (int_cnt == '0) begin
                        state <= S_CAP;
                    end else begin
                        int_cnt <= int_cnt - 1'b1;
                    end
                end
                S_CAP: begin
                    if (rep_cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        rep_cnt <= rep_cnt - 1'b1;
                        int_cnt <= (mode_q == GEMM) ? len_m1_q : ITER_M1;
                        state   <= S_RUN;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Sticky status: a new event in the clear cycle keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_o  <= 1'b0;
            drop_o <= 1'b0;
        end else begin
            if (cap && sat_now) begin
                sat_o <= 1'b1;
            end else if (clr_i) begin
                sat_o <= 1'b0;
            end
            if (drop_now) begin
                drop_o <= 1'b1;
            end else if (clr_i) begin
                drop_o <= 1'b0;
            end
        end
    end

    pe_sync_fifo #(
        .WIDTH (MUL_BW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cap),
        .din   (cnv),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_pe_col_drain.sv
// Bench for pe_col_drain: a schedule/queue reference model predicts every
// output after every clock edge.
module tb_pe_col_drain;

    logic               clk;
    logic               rst_n;
    logic [1:0]         gemm_uno;
    logic               start_i;
    logic [9:0]         len_i;
    logic [7:0]         nrep_i;
    logic signed [31:0] acc_i;
    logic               clr_i;
    logic signed [15:0] out_o;
    logic               out_vld_o;
    logic               out_rdy_i;
    logic               busy_o;
    logic               sat_o;
    logic               drop_o;

    int checks;
    int failures;

    // reference model state
    logic [15:0] q[$];
    bit          m_sat;
    bit          m_drop;
    bit          job_on;
    int          job_l;
    int          job_r;
    int          job_t;

    pe_col_drain dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .gemm_uno  (gemm_uno),
        .start_i   (start_i),
        .len_i     (len_i),
        .nrep_i    (nrep_i),
        .acc_i     (acc_i),
        .clr_i     (clr_i),
        .out_o     (out_o),
        .out_vld_o (out_vld_o),
        .out_rdy_i (out_rdy_i),
        .busy_o    (busy_o),
        .sat_o     (sat_o),
        .drop_o    (drop_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // floor(acc / 2^10) clamped to the signed 16-bit range
    function automatic logic [15:0] conv(input logic [31:0] a, output bit s);
        longint v;
        longint qv;
        v  = longint'($signed(a));
        qv = v / 1024;
        if (v < 0 && (v % 1024) != 0) qv = qv - 1;
        s = 1'b0;
        if (qv > 32767) begin
            qv = 32767;
            s  = 1'b1;
        end else if (qv < -32768) begin
            qv = -32768;
            s  = 1'b1;
        end
        return 16'(qv);
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".busy"}, {31'b0, busy_o}, {31'b0, job_on});
        check({tag, ".vld"}, {31'b0, out_vld_o}, {31'b0, (q.size() > 0)});
        if (q.size() > 0) check({tag, ".out"}, {16'h0, out_o}, {16'h0, q[0]});
        check({tag, ".sat"}, {31'b0, sat_o}, {31'b0, m_sat});
        check({tag, ".drop"}, {31'b0, drop_o}, {31'b0, m_drop});
    endtask

    // drive one cycle of inputs, advance the model by one edge, then compare
    task automatic step(input string tag, input logic [31:0] acc, input bit rdy, input bit st,
                        input logic [1:0] md, input logic [9:0] ln, input logic [7:0] nr,
                        input bit clr);
        bit          pop;
        bit          cap;
        bit          s;
        bit          sev;
        bit          dev;
        logic [15:0] v;
        int          e;
        gemm_uno  = md;
        start_i   = st;
        len_i     = ln;
        nrep_i    = nr;
        acc_i     = acc;
        out_rdy_i = rdy;
        clr_i     = clr;
        pop = rdy && (q.size() > 0);
        e   = job_t + 1;
        cap = job_on && ((e % (job_l + 1)) == 0);
        v   = conv(acc, s);
        sev = cap && s;
        dev = cap && (q.size() == 4) && !pop;
        if (pop) void'(q.pop_front());
        if (cap && !dev) q.push_back(v);
        m_sat  = sev ? 1'b1 : (clr ? 1'b0 : m_sat);
        m_drop = dev ? 1'b1 : (clr ? 1'b0 : m_drop);
        if (job_on) begin
            job_t = e;
            if (e == job_r * (job_l + 1)) job_on = 1'b0;
        end else if (st) begin
            job_on = 1'b1;
            job_t  = 0;
            job_l  = (md == 2'b00) ? ((ln == 0) ? 1 : int'(ln)) : 8;
            job_r  = (nr == 0) ? 1 : int'(nr);
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle_steps(input string tag, input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(tag, 32'h0, rdy, 1'b0, 2'b00, 10'd0, 8'd0, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".busy"}, {31'b0, busy_o}, 32'h0);
        check({tag, ".vld"}, {31'b0, out_vld_o}, 32'h0);
        check({tag, ".out"}, {16'h0, out_o}, 32'h0);
        check({tag, ".sat"}, {31'b0, sat_o}, 32'h0);
        check({tag, ".drop"}, {31'b0, drop_o}, 32'h0);
    endtask

    logic [31:0] sat_vals [3];
    logic [31:0] ovr_vals [6];
    logic [31:0] racc;

    initial begin
        checks    = 0;
        failures  = 0;
        m_sat     = 1'b0;
        m_drop    = 1'b0;
        job_on    = 1'b0;
        job_l     = 1;
        job_r     = 1;
        job_t     = 0;
        rst_n     = 1'b0;
        gemm_uno  = 2'b00;
        start_i   = 1'b0;
        len_i     = '0;
        nrep_i    = '0;
        acc_i     = '0;
        clr_i     = 1'b0;
        out_rdy_i = 1'b0;

        #1;
        check_reset_state("reset");
        #11;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("post_reset");

        // basic gemm capture: L=3, R=1, capture at edge 4 -> 0x0C00
        step("basic", 32'h0030_0000, 1'b0, 1'b1, 2'b00, 10'd3, 8'd1, 1'b0);
        for (int c = 1; c <= 5; c++) step("basic", 32'h0030_0000, 1'b0, 1'b0, 2'b00, 10'd3, 8'd1, 1'b0);
        check("basic.value", {16'h0, out_o}, 32'h0000_0C00);
        idle_steps("basic_drain", 3, 1'b1);

        // saturation high/low and a negative in-range value
        sat_vals[0] = 32'h7FFF_FFFF;
        sat_vals[1] = 32'h8000_0000;
        sat_vals[2] = 32'hFFF0_0000;
        step("sat", 32'h0, 1'b0, 1'b1, 2'b00, 10'd1, 8'd3, 1'b0);
        for (int c = 1; c <= 7; c++) step("sat", sat_vals[(c - 1) / 2 < 3 ? (c - 1) / 2 : 2], 1'b0, 1'b0, 2'b00, 10'd1, 8'd3, 1'b0);
        check("sat.head", {16'h0, out_o}, 32'h0000_7FFF);
        idle_steps("sat_drain", 4, 1'b1);
        step("sat_clr", 32'h0, 1'b0, 1'b0, 2'b00, 10'd0, 8'd0, 1'b1);
        check("sat.cleared", {31'b0, sat_o}, 32'h0);

        // overrun: six captures into a four-deep FIFO with no consumer
        for (int i = 0; i < 6; i++) ovr_vals[i] = 32'($urandom_range(0, 32'h00FF_FFFF)) + 32'(i << 12);
        step("ovr", 32'h0, 1'b0, 1'b1, 2'b00, 10'd1, 8'd6, 1'b0);
        for (int c = 1; c <= 13; c++) step("ovr", ovr_vals[(c - 1) / 2 < 6 ? (c - 1) / 2 : 5], 1'b0, 1'b0, 2'b00, 10'd1, 8'd6, 1'b0);
        check("ovr.drop", {31'b0, drop_o}, 32'h1);
        step("ovr_clr", 32'h0, 1'b0, 1'b0, 2'b00, 10'd0, 8'd0, 1'b1);

        // FIFO still full; capture coincides with a pop -> no drop
        step("fullpop", 32'h0, 1'b0, 1'b1, 2'b00, 10'd2, 8'd1, 1'b0);
        step("fullpop", 32'h0, 1'b0, 1'b0, 2'b00, 10'd0, 8'd0, 1'b0);
        step("fullpop", 32'h0, 1'b0, 1'b0, 2'b00, 10'd0, 8'd0, 1'b0);
        step("fullpop", 32'h0123_4567, 1'b1, 1'b0, 2'b00, 10'd0, 8'd0, 1'b0);
        check("fullpop.nodrop", {31'b0, drop_o}, 32'h0);
        idle_steps("fullpop_drain", 6, 1'b1);

        // unary mode with a mid-run start that must be ignored
        step("unary", 32'h0, 1'b1, 1'b1, 2'b10, 10'd50, 8'd2, 1'b0);
        for (int c = 1; c <= 20; c++) begin
            racc = $urandom();
            step("unary", racc, $urandom_range(0, 1) == 1, c == 5, 2'b00, 10'd3, 8'd7, 1'b0);
        end
        idle_steps("unary_drain", 3, 1'b1);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            racc = $urandom();
            if ($urandom_range(0, 1) == 1) racc = 32'($signed(racc) >>> 7);
            step("rand", racc, $urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0,
                 2'($urandom_range(0, 3)), 10'($urandom_range(0, 4)), 8'($urandom_range(0, 5)),
                 $urandom_range(0, 15) == 0);
        end
        idle_steps("rand_drain", 60, 1'b1);

        // reset mid-run with two entries queued
        step("rstmid", 32'h0, 1'b0, 1'b1, 2'b00, 10'd1, 8'd6, 1'b0);
        for (int c = 1; c <= 5; c++) step("rstmid", 32'h8000_0000, 1'b0, 1'b0, 2'b00, 10'd1, 8'd6, 1'b0);
        check("rstmid.queued", {31'b0, out_vld_o}, 32'h1);
        #2;
        start_i = 1'b0;
        rst_n   = 1'b0;
        #1;
        check_reset_state("rstmid.async");
        q.delete();
        m_sat  = 1'b0;
        m_drop = 1'b0;
        job_on = 1'b0;
        job_t  = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("rstmid.release");
        idle_steps("rstmid.quiet", 20, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pe_col_drain.md
Name: pe_col_drain

Overview:
- Sits directly downstream of the bottom PE of one systolic column and consumes its accumulator output (o_o).
- Runs a capture schedule set by a start command and samples the 32-bit accumulator at the correct cycle.
- Saturates and rounds each sample to the 16-bit Q(INT_BW).(FRA_BW) activation format.
- Buffers results in a small FIFO and presents them on a valid/ready stream to the writeback logic.

Parameters:
- INT_BW, 5, integer bits of the activation format.
- FRA_BW, 10, fraction bits of the activation format; the accumulator carries 2*FRA_BW fraction bits.
- MUL_BW, 16, activation width; equals 1+INT_BW+FRA_BW.
- ACC_BW, 32, accumulator width.
- LEN_BW, 10, width of len_i.
- REP_BW, 8, width of nrep_i.
- ITER_LEN, 8, capture interval in cycles for unary modes (div/exp/log).
- DEPTH, 4, FIFO entries; must be a power of two, at least 2.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous reset, active low.
- gemm_uno, in, 2, mode: 00 gemm, 01 div, 10 exp, 11 log; sampled with start_i.
- start_i, in, 1, start pulse; accepted only in IDLE.
- len_i, in, LEN_BW, gemm capture interval in cycles; 0 is treated as 1.
- nrep_i, in, REP_BW, number of captures per start; 0 is treated as 1.
- acc_i, in signed, ACC_BW, accumulator from the bottom PE (o_o).
- clr_i, in, 1, synchronous clear of the sticky flags.
- out_o, out signed, MUL_BW, FIFO head value.
- out_vld_o, out, 1, FIFO not empty.
- out_rdy_i, in, 1, consumer ready.
- busy_o, out, 1, FSM not in IDLE.
- sat_o, out, 1, sticky flag: a captured sample was saturated.
- drop_o, out, 1, sticky flag: a capture was lost because the FIFO was full.

Behaviour:
- Reset (asynchronous, any time, including mid-run): FSM goes to IDLE; counters are 0; FIFO is empty; out_vld_o=0, busy_o=0, sat_o=0, drop_o=0, out_o=0.
- FSM states: IDLE, RUN, CAP.
- IDLE -> RUN on start_i.
  - Latch mode.
  - Load the interval counter with L-1, where L = max(len_i,1) for gemm or ITER_LEN for unary modes.
  - Load the repeat counter with max(nrep_i,1)-1.
- RUN: decrement the interval counter each cycle; go to CAP when it reaches 0.
- CAP (exactly one cycle):
  - Sample acc_i.
  - If the repeat counter is 0, go to IDLE.
  - Otherwise decrement it, reload the interval counter with L-1 and go to RUN.
- Capture timing: start_i is sampled at edge 0, and the k-th capture (k=1..R) samples acc_i in the cycle ending at edge k*(L+1).
- While FSM != IDLE, start_i, len_i, nrep_i and gemm_uno are ignored.
- Conversion (combinational on acc_i):
  - Compute s = acc_i >>> FRA_BW (arithmetic shift).
  - If s > 2^(MUL_BW-1)-1, result = 0x7FFF.
  - If s < -2^(MUL_BW-1), result = 0x8000.
  - Otherwise result = s[MUL_BW-1:0] (truncation toward minus infinity).
  - Saturation in a CAP cycle sets sat_o.
- FIFO push happens in the CAP cycle.
  - The push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the sample is discarded and drop_o is set; the FSM never stalls.
- Pop occurs when out_vld_o && out_rdy_i.
- Push and pop in the same cycle:
  - When empty, the new value appears on out_o the next cycle.
  - When full, the occupancy stays at DEPTH.
- Ordering is strict FIFO; pointers wrap modulo DEPTH.
- out_o is a don't-care while out_vld_o=0.
- Sticky flags: clr_i clears sat_o and drop_o on the next edge. If a new sat or drop event occurs in the same cycle as clr_i, the event wins and the flag stays 1.
- Latency: a captured value is visible on out_o one cycle after its CAP edge when the FIFO was empty.

Decomposition:
- raven_pkg (shared package):
  - typedef enum logic [1:0] gemm_uno_e {GEMM=2'b00, DIV=2'b01, EXP=2'b10, LOG=2'b11}.
  - Drain FSM state enum.
  - Saturation bound constants derived from MUL_BW.
- Sub-module: pe_sync_fifo, parameterised by width and DEPTH, with push/pop/full/empty and a registered head. The saturator stays inline as an always_comb block.

Test Plan:
- Basic gemm capture:
  - Stimulus: gemm_uno=00, len_i=3, nrep_i=1, start at edge 0, acc_i=0x0030_0000 held.
  - Response: CAP at edge 4; out_o=0x0C00 with out_vld_o=1 after edge 4; busy_o falls after edge 4.
- Saturation:
  - Stimulus: captures of acc_i=0x7FFF_FFFF, then 0x8000_0000, then 0xFFF0_0000.
  - Response: out_o sequence 0x7FFF, 0x8000, 0xFC00; sat_o=1 from the first capture; clr_i then clears sat_o.
- Overrun:
  - Stimulus: out_rdy_i=0, nrep_i=6, len_i=1, distinct acc_i per capture.
  - Response: first 4 values are retained in order; drop_o=1 at the 5th capture; draining yields exactly 4 entries.
- Full with simultaneous pop:
  - Stimulus: FIFO full, out_rdy_i=1 in a CAP cycle.
  - Response: no drop; the oldest entry is popped and the new value is appended; occupancy stays 4.
- Unary mode and ignored start:
  - Stimulus: gemm_uno=10, len_i=50, nrep_i=2, with start_i re-pulsed mid-run.
  - Response: captures at edges 9 and 18 (ITER_LEN=8); the second start has no effect.
- Reset mid-run:
  - Stimulus: rst_n low during RUN with 2 entries queued.
  - Response: out_vld_o, busy_o and the flags go to 0 immediately; after release no spurious capture occurs without a new start.
